// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_gen
// Brief    : Fractional-rate clock-enable generator (phase accumulators) with
//            PLL lock synchronisation and stability qualification.
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
    parameter int                              CHANNELS           = 4,
    parameter int                              ACC_WIDTH          = 24,
    parameter int                              LOCK_STABLE_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_WIDTH-1:0]   INC_INIT           = {4{24'h100000}}
) (
    input  logic                  clkin,
    input  logic                  rstn,
    input  logic                  pll_locked,
    input  logic [CHANNELS-1:0]   ch_en,
    input  logic                  inc_we,
    input  logic [3:0]            inc_sel,
    input  logic [ACC_WIDTH-1:0]  inc_data,
    output logic [CHANNELS-1:0]   ce,
    output logic                  sys_ready
);

    localparam int                 c_cnt_w   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(LOCK_STABLE_CYCLES);

    logic               r_s1;
    logic               r_s2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_run_ok;

    // Lock synchroniser and saturating stability counter
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= pll_locked;
            r_s2 <= r_s1;
            if (!r_s2) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign sys_ready = (r_cnt == c_cnt_max);

    // r_s2 low means the counter clears on this edge, so channels stop together with sys_ready
    assign w_run_ok = sys_ready & r_s2;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [ACC_WIDTH-1:0] r_acc;
        logic [ACC_WIDTH-1:0] r_inc;
        logic                 r_ce;
        logic [ACC_WIDTH:0]   w_sum;
        logic                 w_we;

        assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_we  = inc_we && (inc_sel == 4'(gi));

        always_ff @(posedge clkin) begin
            if (!rstn) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
                r_inc <= INC_INIT[gi*ACC_WIDTH +: ACC_WIDTH];
            end else begin
                if (w_we) begin
                    r_inc <= inc_data;
                end
                if (ch_en[gi] && w_run_ok) begin
                    r_acc <= w_sum[ACC_WIDTH-1:0];
                    r_ce  <= w_sum[ACC_WIDTH];
                end else begin
                    r_acc <= '0;
                    r_ce  <= 1'b0;
                end
            end
        end

        assign ce[gi] = r_ce;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_enable_gen
// Brief    : Scoreboard bench for clk_enable_gen plus directed timing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_enable_gen;

    localparam int                    c_ch   = 4;
    localparam int                    c_w    = 24;
    localparam int                    c_lsc  = 16;
    localparam logic [c_ch*c_w-1:0]   c_init = {4{24'h100000}};

    logic              clk = 1'b0;
    logic              rstn;
    logic              pll_locked;
    logic [c_ch-1:0]   ch_en;
    logic              inc_we;
    logic [3:0]        inc_sel;
    logic [c_w-1:0]    inc_data;
    logic [c_ch-1:0]   ce;
    logic              sys_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .CHANNELS           (c_ch),
        .ACC_WIDTH          (c_w),
        .LOCK_STABLE_CYCLES (c_lsc),
        .INC_INIT           (c_init)
    ) dut (
        .clkin      (clk),
        .rstn       (rstn),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .inc_we     (inc_we),
        .inc_sel    (inc_sel),
        .inc_data   (inc_data),
        .ce         (ce),
        .sys_ready  (sys_ready)
    );

    // ------------------------------------------------------------------
    // Reference model: lock qualification as a window over sampled lock
    // history, channels as an unbounded phase whose integer part ticks.
    // ------------------------------------------------------------------
    logic [c_lsc+1:0]   m_hist;
    logic               m_ready;
    longint unsigned    m_ph  [c_ch];
    logic [c_w-1:0]     m_inc [c_ch];
    logic [c_ch:0]      exp_q [$];

    always @(posedge clk) begin : model
        logic            rdy_new;
        logic [c_ch-1:0] ce_n;
        longint unsigned whole;
        ce_n = '0;
        if (!rstn) begin
            m_hist  = '0;
            m_ready = 1'b0;
            for (int i = 0; i < c_ch; i++) begin
                m_ph[i]  = 0;
                m_inc[i] = c_init[i*c_w +: c_w];
            end
        end else begin
            m_hist  = {m_hist[c_lsc:0], pll_locked};
            rdy_new = &m_hist[c_lsc+1:2];
            for (int i = 0; i < c_ch; i++) begin
                if (ch_en[i] && m_ready && rdy_new) begin
                    whole    = m_ph[i] >> c_w;
                    m_ph[i]  = m_ph[i] + longint'(m_inc[i]);
                    ce_n[i]  = ((m_ph[i] >> c_w) != whole);
                end else begin
                    m_ph[i] = 0;
                end
            end
            if (inc_we && (inc_sel < 4'(c_ch))) begin
                m_inc[inc_sel[1:0]] = inc_data;
            end
            m_ready = rdy_new;
        end
        exp_q.push_back({m_ready, ce_n});
    end

    // Monitor: pops one expected response per clock and compares
    initial begin : monitor
        logic [c_ch:0] exp_v;
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t actual ready=%b ce=%b required an expected entry",
                         $time, sys_ready, ce);
            end else begin
                exp_v = exp_q.pop_front();
                if ({sys_ready, ce} !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t actual ready=%b ce=%b required ready=%b ce=%b",
                             $time, sys_ready, ce, exp_v[c_ch], exp_v[c_ch-1:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    task automatic write_inc(input logic [3:0] sel, input logic [c_w-1:0] val);
        inc_we   = 1'b1;
        inc_sel  = sel;
        inc_data = val;
        tick(1);
        inc_we   = 1'b0;
    endtask

    initial begin : stim
        int cnt0, cnt1, cnt2, cnt3, first1, last1, badgap;

        rstn       = 1'b0;
        pll_locked = 1'b0;
        ch_en      = '0;
        inc_we     = 1'b0;
        inc_sel    = '0;
        inc_data   = '0;
        tick(3);
        chk("reset_ready", sys_ready, 0);
        chk("reset_ce", ce, 0);

        // Lock qualification: edge 1 is the first to see rstn=1 and pll_locked=1
        rstn       = 1'b1;
        pll_locked = 1'b1;
        tick(17);
        chk("ready_edge17", sys_ready, 0);
        chk("ce_before_ready", ce, 0);
        tick(1);
        chk("ready_edge18", sys_ready, 1);

        // Half-rate channel 0
        write_inc(4'd0, 24'h800000);
        ch_en = 4'b0001;
        cnt0  = 0;
        for (int n = 1; n <= 100; n++) begin
            tick(1);
            if (n <= 6) chk($sformatf("ch0_half_edge%0d", n), ce[0], (n % 2 == 0));
            cnt0 += ce[0];
        end
        chk("ch0_density_100", cnt0, 50);

        // Mid-run write: acc0 reaches 0x800000, then write edge still adds 0x800000
        tick(1);
        chk("ch0_prewrite", ce[0], 0);
        write_inc(4'd0, 24'h400000);
        chk("ch0_write_edge_carry", ce[0], 1);
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            chk($sformatf("ch0_quarter_edge%0d", n), ce[0], (n % 4 == 0));
        end

        // Out-of-range selects must not touch any increment
        write_inc(4'd7, 24'h000001);
        write_inc(4'd4, 24'h000000);
        cnt0 = 0;
        for (int n = 1; n <= 40; n++) begin
            tick(1);
            cnt0 += ce[0];
        end
        chk("ch0_after_bad_sel", cnt0, 10);

        // Fractional, zero and default increments side by side
        write_inc(4'd1, 24'h555555);
        write_inc(4'd2, 24'h000000);
        ch_en  = 4'b1111;
        cnt1   = 0;
        cnt2   = 0;
        cnt3   = 0;
        first1 = 0;
        last1  = 0;
        badgap = 0;
        for (int n = 1; n <= 3000; n++) begin
            tick(1);
            if (ce[1]) begin
                if (first1 == 0) first1 = n;
                else if ((n - last1) != 3 && (n - last1) != 4) badgap++;
                last1 = n;
                cnt1++;
            end
            cnt2 += ce[2];
            cnt3 += ce[3];
        end
        chk("ch1_first_pulse", first1, 4);
        chk("ch1_bad_gaps", badgap, 0);
        chk("ch1_count_3000", cnt1, 999);
        chk("ch2_zero_inc", cnt2, 0);
        chk("ch3_default_count", cnt3, 187);

        // One-cycle lock glitch, sampled low at edge a
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        chk("glitch_a_ready", sys_ready, 1);
        tick(1);
        chk("glitch_a1_ready", sys_ready, 1);
        tick(1);
        chk("glitch_a2_ready", sys_ready, 0);
        chk("glitch_a2_ce", ce, 0);
        write_inc(4'd0, 24'h800000);
        tick(14);
        chk("glitch_a17_ready", sys_ready, 0);
        tick(1);
        chk("glitch_a18_ready", sys_ready, 1);
        chk("glitch_a18_ce0", ce[0], 0);
        tick(1);
        chk("relock_run1_ce0", ce[0], 0);
        tick(1);
        chk("relock_run2_ce0", ce[0], 1);

        // Reset mid-run after runtime writes
        write_inc(4'd1, 24'h123456);
        tick(5);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("midrst_ce", ce, 0);
        chk("midrst_ready", sys_ready, 0);
        tick(17);
        chk("postrst_ready17", sys_ready, 0);
        tick(1);
        chk("postrst_ready18", sys_ready, 1);
        tick(15);
        chk("postrst_run15_ce", ce, 4'b0000);
        tick(1);
        chk("postrst_run16_ce", ce, 4'b1111);

        tick(2);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised clock-enable generator, the successor to the fixed-ratio PLL output set.
- Runs in one PLL-derived system clock domain and produces CHANNELS independent single-cycle clock-enable pulses at runtime-programmable fractional rates, using phase accumulators.
- Also qualifies the PLL lock signal (synchronise plus stability count) and drives a system-ready flag.
- Replaces spare PLL outputs for slow clocks such as the CPU and tape clocks.

Parameters:
- CHANNELS, 4, number of enable outputs (1..16).
- ACC_WIDTH, 24, phase accumulator and increment width in bits (8..32).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before ready (>=1).
- INC_INIT, {4{24'h100000}}, packed CHANNELS*ACC_WIDTH reset increments; channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous reset, active low.
- pll_locked  in  1  PLL lock, asynchronous to clkin.
- ch_en  in  CHANNELS  per-channel run enable.
- inc_we  in  1  increment write strobe.
- inc_sel  in  4  channel index for the write.
- inc_data  in  ACC_WIDTH  new increment value.
- ce  out  CHANNELS  registered enable pulses.
- sys_ready  out  1  lock qualified and stable.

Behaviour:
- Reset (rstn=0 at an edge):
  - Sync flops, lock counter, all accumulators and ce are cleared to 0; sys_ready=0.
  - inc[i] is loaded from INC_INIT.
  - Reset takes priority over every other event, including mid-count and mid-write.
- Lock sync:
  - Two-flop synchroniser s1→s2 on pll_locked.
  - cnt (clog2(LOCK_STABLE_CYCLES+1) bits) increments on each edge with s2=1 and saturates at LOCK_STABLE_CYCLES.
  - Any edge with s2=0 clears cnt to 0.
  - sys_ready = (cnt==LOCK_STABLE_CYCLES), decoded from the register with no extra stage.
- Ready timing:
  - pll_locked is first sampled high at edge 1, so s2=1 after edge 2 and sys_ready rises after edge LOCK_STABLE_CYCLES+2.
  - Lock loss drops sys_ready 2 edges after pll_locked falls. A glitch of at least 1 cycle on s2 restarts the full count.
- Channel gating: channel i runs only when ch_en[i]=1 and sys_ready=1. Otherwise acc[i] is forced to 0 and ce[i]=0.
- Accumulator, per running channel, each edge:
  - {carry, acc[i]} <= acc[i] + inc[i], an (ACC_WIDTH+1)-bit sum wrapping modulo 2^ACC_WIDTH.
  - ce[i] <= carry.
- Rate:
  - Average rate is f_clkin*inc/2^ACC_WIDTH.
  - ce is high for exactly 1 cycle per pulse. Gaps are floor or ceil of 2^ACC_WIDTH/inc, with no cumulative drift.
- Increment edge values:
  - inc=0: channel never pulses.
  - inc=2^ACC_WIDTH-1: pulses on every edge except one in 2^ACC_WIDTH.
  - 1 ce pulse per cycle is the maximum rate; inc cannot represent a division below 1.
- First pulse: from acc=0, the first ce rises after edge ceil(2^ACC_WIDTH/inc) counted from the first running edge.
- Increment write:
  - Accepted on an edge with inc_we=1 and inc_sel<CHANNELS; writes with inc_sel>=CHANNELS are ignored.
  - The new value is used from the following edge. The edge of the write itself still adds the old inc.
  - acc is not cleared by a write, so the phase stays continuous.
  - Writes are accepted whether or not the channel is running or sys_ready is high.
- Simultaneous events:
  - ch_en[i] falling on the same edge as a carry: ce[i]=0 and acc is cleared.
  - Lock loss clears all channels on the same edge sys_ready falls.
- Outputs are driven directly from flops; no combinational path from inputs to outputs.

Test Plan:
1. Reset with INC_INIT default and LOCK_STABLE_CYCLES=16; raise pll_locked at edge 1 → sys_ready=0 through edge 17, rises after edge 18; all ce=0 before that.
2. ACC_WIDTH=24, ready, ch_en=4'b0001, inc0=24'h800000 → ce[0] high after edges 2,4,6,…; exactly 50% pulse density over 100 cycles.
3. inc1=24'h555555 over 3×2^24/0x555555 span → ce[1] gaps of 3/4 cycles only, pulse count within ±1 of cycles/3.0000002; inc2=0 for 1000 cycles → zero pulses.
4. Write inc0=24'h400000 mid-run while acc0=24'h800000 → write edge adds old inc (carry, ce[0]=1 after it), then period 4 with next pulse 4 edges later; write inc_sel=7 with CHANNELS=4 → no increment changes.
5. Drop pll_locked for 1 cycle at cycle 500 → sys_ready falls 2 edges later, all ce stop, acc cleared; returns high 18 edges after lock reasserts; first ce[0] after edge 2 of running (inc=24'h800000).
6. Assert rstn=0 mid-run for 1 cycle after runtime inc writes → outputs 0 on that edge, inc values restored to INC_INIT, lock count restarts from 0.
